// File: rtl/wide_addsub_pkg.sv
// Shared types and constants for the byte-serial wide add/sub sequencer.
package wide_addsub_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/addsub8_slice.sv
// Combinational byte-wide add/sub slice built from a chain of 1-bit full-adder cells.
// sub only inverts b; the +1 of two's complement comes in through carry_in on the
// lowest byte, so upper bytes can chain the real carry without re-injecting it.
module addsub8_slice
    import wide_addsub_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              sub,
    input  logic              carry_in,
    output logic [BYTE_W-1:0] y,
    output logic              carry_out,
    output logic              c7
);

    logic [BYTE_W-1:0] b_eff;
    logic [BYTE_W:0]   c;

    // Ripple through one full-adder cell per bit.
    always_comb begin
        b_eff = b ^ {BYTE_W{sub}};
        c     = '0;
        y     = '0;
        c[0]  = carry_in;
        for (int i = 0; i < BYTE_W; i++) begin
            y[i]   = a[i] ^ b_eff[i] ^ c[i];
            c[i+1] = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
        end
    end

    assign carry_out = c[BYTE_W];
    assign c7        = c[BYTE_W-1];

endmodule

// File: rtl/wide_addsub_seq.sv
// WORDS x 8-bit add/subtract sequenced one byte per cycle through a single shared
// addsub8_slice, with valid/ready handshakes on operands and result.
module wide_addsub_seq
    import wide_addsub_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BYTE_W*WORDS-1:0] a,
    input  logic [BYTE_W*WORDS-1:0] b,
    input  logic                    sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BYTE_W*WORDS-1:0] y,
    output logic                    carry_out,
    output logic                    overflow
);

    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned W     = BYTE_W * WORDS;

    state_e             state_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               sub_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;

    logic [BYTE_W-1:0]  a_byte;
    logic [BYTE_W-1:0]  b_byte;
    logic [BYTE_W-1:0]  sum_byte;
    logic               slice_co;
    logic               slice_c7;
    logic               last_byte;

    // Select the operand bytes addressed by the current index.
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_byte = a_q[i*BYTE_W +: BYTE_W];
                b_byte = b_q[i*BYTE_W +: BYTE_W];
            end
        end
        last_byte = (idx_q == IDX_W'(WORDS - 1));
    end

    addsub8_slice u_slice (
        .a         (a_byte),
        .b         (b_byte),
        .sub       (sub_q),
        .carry_in  (carry_q),
        .y         (sum_byte),
        .carry_out (slice_co),
        .c7        (slice_c7)
    );

    // Control FSM with operand, carry and result registers; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            y         <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        sub_q    <= sub;
                        carry_q  <= sub;  // +1 of two's complement on byte 0
                        idx_q    <= '0;
                        in_ready <= 1'b0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            y[i*BYTE_W +: BYTE_W] <= sum_byte;
                        end
                    end
                    carry_q <= slice_co;
                    if (last_byte) begin
                        carry_out <= slice_co;
                        overflow  <= slice_c7 ^ slice_co;
                        out_valid <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wide_addsub_seq.md
# wide_addsub_seq

Multi-cycle sequencer that performs WORDS×8-bit add or subtract by passing operands one byte per cycle through a single shared 8-bit add/sub slice and chaining the carry between bytes. It sits in front of the 8-bit adder datapath, so wide arithmetic reuses one byte-wide adder instead of a full-width ripple or carry-lookahead chain. Operands enter and results leave through valid/ready handshakes.

## Interface
- WORDS, default 4, number of 8-bit bytes per operand; must be ≥1.
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low; the only reset
- in_valid  input  1  operand presented
- in_ready  output  1  block can accept operands (IDLE only)
- a  input  8*WORDS  operand A, unsigned or two's complement
- b  input  8*WORDS  operand B
- sub  input  1  1: y = a − b; 0: y = a + b
- out_valid  output  1  result held on y/carry_out/overflow
- out_ready  input  1  consumer takes the result
- y  output  8*WORDS  result, modulo 2^(8*WORDS)
- carry_out  output  1  final carry; for sub, 1 = no borrow (a ≥ b unsigned)
- overflow  output  1  signed overflow of the full-width operation

## Operation
- Three-state FSM: IDLE → RUN → DONE → IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, latch a, b and sub; set byte index idx=0 and carry register to sub; go to RUN. Input values are ignored after the accept edge.
- RUN: each cycle the slice computes a[idx] + (b[idx] ^ {8{sub}}) + carry.
  - Write the slice sum into result byte idx.
  - Load the slice carry-out into the carry register.
  - For idx = WORDS−1, also capture overflow = carry into bit 7 ^ carry out of bit 7.
  - If idx = WORDS−1, go to DONE; otherwise increment idx.
- DONE: out_valid=1; y, carry_out and overflow stay stable. On out_valid&out_ready, go to IDLE.
- No input bypass: in_ready is 0 in RUN and DONE, so there is at most one operation in flight.
- idx is $clog2(WORDS) bits wide, minimum 1 bit. idx never wraps past WORDS−1.
- Reset, at any time including mid-RUN or in DONE: immediately enter IDLE; clear y, carry_out, overflow, idx, the carry register and the latched operands to 0. A partial result is discarded and never presented.
- Reset values: in_ready=1, out_valid=0, y=0, carry_out=0, overflow=0.

## Timing
- Accept edge = cycle 0. RUN occupies cycles 1..WORDS; out_valid rises on the edge ending cycle WORDS.
- Latency from accept edge to out_valid is WORDS cycles (4 at default).
- Result handshake edge with out_ready=1 in DONE: out_valid falls and in_ready rises on that same edge. The earliest next accept is one cycle later.
- Peak throughput is one operation per WORDS+2 cycles.
- out_ready may be held high in advance; it is sampled only in DONE.
- Asserting in_valid while in_ready=0 has no effect. The source must hold its operands until the handshake.
- y bytes update progressively during RUN. They are not guaranteed meaningful until out_valid.

## Structure
- Package wide_addsub_pkg holds:
  - the state enum {IDLE, RUN, DONE}
  - localparam BYTE_W = 8
- Sub-module addsub8_slice: combinational byte adder.
  - Inputs: a[7:0], b[7:0], sub, carry_in.
  - Outputs: y[7:0], carry_out, c7 (carry into bit 7).
  - It has separate sub and carry_in inputs, because chained bytes need inversion without re-injecting +1.
  - It is built from the 1-bit full-adder cell.
- Top level contains the FSM, operand registers, byte mux, carry register and result register.

## Test plan
All scenarios use WORDS=4.
- Add 0x000000FF + 0x00000001, sub=0 → y=0x00000100, carry_out=0, overflow=0, out_valid exactly 4 cycles after accept.
- Add 0xFFFFFFFF + 0x00000001 → y=0x00000000, carry_out=1, overflow=0; add 0x7FFFFFFF + 0x00000001 → y=0x80000000, overflow=1.
- Sub 0x00000100 − 0x00000001 → y=0x000000FF, carry_out=1; sub 0x00000000 − 0x00000001 → y=0xFFFFFFFF, carry_out=0, overflow=0; sub 0x80000000 − 0x00000001 → overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → y, carry_out and overflow stable, in_ready=0, and a new in_valid is ignored; release → one handshake, then in_ready=1 the next cycle.
- Back-to-back: in_valid held high with two queued operations → second accept occurs exactly WORDS+2 cycles after the first, and both results are correct.
- Drop rst_n during RUN at idx=2 → in the same cycle out_valid=0, in_ready=1, y=0; after release a fresh 0x12345678 + 0x11111111 → y=0x23456789, carry_out=0.
